seed_round_ctrl: RTL and testbench

SEED_ROUND_CTRL -- requirements
Module: seed_round_ctrl

---
 rtl/seed_round_ctrl.sv | 101 ++++++++++
 tb/tb_seed_round_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seed_round_ctrl.sv
// Round/byte sequencer for a SEED-style Feistel block engine.
// Walks NUM_ROUNDS rounds of ROUND_CYCLES byte steps, stalling on key_valid, then hands the block off.
module seed_round_ctrl #(
  parameter int NUM_ROUNDS   = 16,
  parameter int ROUND_CYCLES = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       key_valid,
  input  logic       out_ready,
  output logic [4:0] main_counter,
  output logic [3:0] round,
  output logic       in_ready,
  output logic       busy,
  output logic       key_req,
  output logic       load_phase,
  output logic       swap_en,
  output logic       last_round,
  output logic       out_valid,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [4:0] CNT_LAST = 5'(ROUND_CYCLES - 1);
  localparam logic [3:0] RND_LAST = 4'(NUM_ROUNDS - 1);

  state_t     state;
  logic       step;
  logic       round_end;
  logic       final_round;

  // A step only happens in RUN with a subkey byte present and no abort pending.
  assign step        = (state == RUN) && key_valid && !abort;
  assign round_end   = step && (main_counter == CNT_LAST);
  assign final_round = (round == RND_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      main_counter <= '0;
      round        <= '0;
    end else begin
      case (state)
        IDLE: begin
          main_counter <= '0;
          round        <= '0;
          if (start && !abort) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state        <= IDLE;
            main_counter <= '0;
            round        <= '0;
          end else if (round_end) begin
            main_counter <= '0;
            if (final_round) begin
              state <= OUT;
            end else begin
              round <= round + 4'd1;
            end
          end else if (step) begin
            main_counter <= main_counter + 5'd1;
          end
        end
        OUT: begin
          if (abort || out_ready) begin
            state        <= IDLE;
            main_counter <= '0;
            round        <= '0;
          end
        end
        default: begin
          state        <= IDLE;
          main_counter <= '0;
          round        <= '0;
        end
      endcase
    end
  end

  // Status outputs are pure decodes of registered state; the two strobes
  // must land in the same cycle as the event that causes them.
  assign in_ready   = (state == IDLE);
  assign busy       = (state == RUN) || (state == OUT);
  assign key_req    = (state == RUN) && (main_counter < 5'd8);
  assign load_phase = (state == RUN) && (main_counter < 5'd8);
  assign last_round = (state == RUN) && final_round;
  assign out_valid  = (state == OUT);
  assign swap_en    = round_end && !final_round;
  assign done       = (state == OUT) && out_ready && !abort;

endmodule

// File: tb/tb_seed_round_ctrl.sv
// Directed bench for seed_round_ctrl with default parameters (16 rounds x 24 cycles).
module tb_seed_round_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic       key_valid;
  logic       out_ready;
  logic [4:0] main_counter;
  logic [3:0] round;
  logic       in_ready, busy, key_req, load_phase, swap_en, last_round, out_valid, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int swaps = 0;
  int lastc = 0;

  always #5 clk = ~clk;

  seed_round_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .key_valid    (key_valid),
    .out_ready    (out_ready),
    .main_counter (main_counter),
    .round        (round),
    .in_ready     (in_ready),
    .busy         (busy),
    .key_req      (key_req),
    .load_phase   (load_phase),
    .swap_en      (swap_en),
    .last_round   (last_round),
    .out_valid    (out_valid),
    .done         (done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_block();
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    #1;
    chk("run_busy", int'(busy), 1);
    chk("run_cnt0", int'(main_counter), 0);
    chk("run_keyreq0", int'(key_req), 1);
  endtask

  // Runs with key_valid=1 until out_valid, counting swap strobes and last_round cycles.
  task automatic run_until_out();
    int guard;
    guard = 0;
    swaps = 0;
    lastc = 0;
    key_valid = 1'b1;
    #1;
    while (!out_valid && guard < 1000) begin
      if (swap_en) swaps++;
      if (last_round) lastc++;
      tick();
      guard++;
    end
    chk("out_reached", int'(out_valid), 1);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b1;
    abort     = 1'b0;
    key_valid = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(main_counter), 0);
    chk("rst_round", int'(round), 0);
    chk("rst_keyreq", int'(key_req | load_phase | swap_en | last_round), 0);
    chk("rst_outv_done", int'(out_valid | done), 0);
    start   = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", int'(in_ready), 1);

    // Full block, no stalls, immediate consume.
    begin_block();
    run_until_out();
    chk("lat_384", cyc - t0, 384);
    chk("swaps_15", swaps, 15);
    chk("last_round_cycles", lastc, 24);
    chk("done_first_out", int'(done), 1);
    chk("out_keyreq", int'(key_req), 0);
    tick();
    chk("done_width", int'(done), 0);
    chk("back_idle", int'(in_ready), 1);
    chk("idle_busy", int'(busy), 0);

    // Stall at round 2, byte 3 for 5 cycles.
    begin_block();
    repeat (51) tick();
    chk("r2_round", int'(round), 2);
    chk("r2_cnt", int'(main_counter), 3);
    key_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_cnt", int'(main_counter), 3);
      chk("stall_keyreq", int'(key_req), 1);
    end
    run_until_out();
    chk("lat_389", cyc - t0, 389);
    tick();

    // Stall right at the round boundary of round 7.
    begin_block();
    repeat (191) tick();
    chk("r7_round", int'(round), 7);
    chk("r7_cnt", int'(main_counter), 23);
    key_valid = 1'b0;
    #1;
    chk("r7_noswap", int'(swap_en), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r7_hold_round", int'(round), 7);
      chk("r7_hold_cnt", int'(main_counter), 23);
      chk("r7_hold_swap", int'(swap_en), 0);
    end
    key_valid = 1'b1;
    #1;
    chk("r7_swap", int'(swap_en), 1);
    tick();
    chk("r8_round", int'(round), 8);
    chk("r8_cnt", int'(main_counter), 0);
    run_until_out();
    chk("lat_387", cyc - t0, 387);
    tick();

    // Back-pressure in OUT; start held meanwhile must not be queued.
    out_ready = 1'b0;
    begin_block();
    run_until_out();
    chk("bp_lat", cyc - t0, 384);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_outv", int'(out_valid), 1);
      chk("bp_nodone", int'(done), 0);
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_done", int'(done), 1);
    tick();
    chk("bp_idle", int'(in_ready), 1);
    chk("bp_outv_low", int'(out_valid), 0);
    tick();
    chk("no_queued_start", int'(in_ready), 1);

    // Abort mid-RUN, then abort+start together in IDLE.
    begin_block();
    repeat (130) tick();
    chk("r5_round", int'(round), 5);
    chk("r5_cnt", int'(main_counter), 10);
    abort = 1'b1;
    #1;
    chk("abort_noswap", int'(swap_en | done), 0);
    tick();
    chk("abort_idle", int'(in_ready), 1);
    chk("abort_round", int'(round), 0);
    chk("abort_cnt", int'(main_counter), 0);
    start = 1'b1;
    tick();
    chk("abort_wins", int'(in_ready), 1);
    chk("abort_wins_busy", int'(busy), 0);
    start = 1'b0;
    abort = 1'b0;
    tick();

    // Abort in OUT: no done.
    out_ready = 1'b0;
    begin_block();
    run_until_out();
    abort = 1'b1;
    #1;
    chk("out_abort_nodone", int'(done), 0);
    tick();
    abort = 1'b0;
    chk("out_abort_idle", int'(in_ready), 1);
    chk("out_abort_outv", int'(out_valid), 0);
    out_ready = 1'b1;

    // Reset in round 9, then a fresh full block.
    begin_block();
    repeat (221) tick();
    chk("r9_round", int'(round), 9);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_idle", int'(in_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_round", int'(round), 0);
    chk("mid_rst_cnt", int'(main_counter), 0);
    chk("mid_rst_keyreq", int'(key_req | load_phase | last_round), 0);
    #2;
    reset_n = 1'b1;
    tick();
    chk("post_rst_wait", int'(in_ready), 1);
    begin_block();
    run_until_out();
    chk("post_rst_lat", cyc - t0, 384);
    chk("post_rst_swaps", swaps, 15);
    chk("post_rst_done", int'(done), 1);
    tick();
    chk("post_rst_final_idle", int'(in_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
